lsu_subword_rmw: RTL and testbench
==================================

# lsu_subword_rmw

Load/store unit between the EX/MEM pipeline register and the word-wide data memory in the pipelined RISC-V core. Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores become a two-cycle read-modify-write, because the memory only writes whole words. Loads are extracted, sign- or zero-extended and registered for the MEM/WB stage.

## Interface
- `ADDR_WIDTH`, 32, byte-address width
- `DAT_WIDTH`, 32, data width; fixed at 32 for RV32I
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req_valid` in 1: MEM-stage instruction is a load or store
- `req_write` in 1: 1 = store, 0 = load
- `req_funct3` in 3: RV32I load/store funct3
- `req_addr` in ADDR_WIDTH: byte address
- `req_wdata` in DAT_WIDTH: store data, right-aligned
- `stall` out 1: freeze IF..MEM pipeline registers this cycle
- `ld_valid` out 1: registered pulse; `ld_data` is valid
- `ld_data` out DAT_WIDTH: extended load result
- `err` out 1: registered pulse; request was misaligned or had an illegal funct3
- `mem_addr` out ADDR_WIDTH: word index, `{2'b0, req_addr[ADDR_WIDTH-1:2]}`
- `mem_wdata` out DAT_WIDTH: word to write
- `mem_write` out 1: memory write enable, sampled at the clock edge
- `mem_read` out 1: memory read enable
- `mem_rdata` in DAT_WIDTH: combinational memory read data

## Operation
- **States:** IDLE, RMW_WR.
- **IDLE, load (`req_valid`, `!req_write`, legal):**
  - `mem_read`=1.
  - Byte lane selected by `addr[1:0]`; halfword lane by `addr[1]`.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Result captured into `ld_data`; `ld_valid`=1 next cycle.
- **IDLE, SW:** `mem_write`=1, `mem_wdata`=`req_wdata`, no stall.
- **IDLE, SB/SH:**
  - `mem_read`=1, `stall`=1.
  - Merged word (`mem_rdata` with the target lane replaced by `req_wdata[7:0]` / `[15:0]`) is registered together with the word index.
  - Go to RMW_WR.
- **RMW_WR:**
  - `mem_write`=1; `mem_wdata` and `mem_addr` come from the registers.
  - `stall`=0; return to IDLE.
  - Request inputs are ignored: it is the same, still-held store.
- **Illegal funct3** (011, 110, 111; stores also 100, 101):
  - No memory access, no stall.
  - `err` pulses next cycle; `ld_valid` stays 0.
- **`req_valid`=0 in IDLE:** `mem_read`=`mem_write`=0; `mem_addr` still follows `req_addr`.
- **Mutual exclusion:** `mem_read` and `mem_write` are never both 1.

## Timing
- **Load latency:** 1 cycle (request cycle N, then `ld_valid`/`ld_data` at N+1). `ld_data` holds its value until the next load.
- **SW:** memory updated at the end of cycle N.
- **SB/SH:** `stall` high in cycle N; write commits at the end of N+1; the pipeline advances after N+1.
- **Back-to-back:**
  - A load at N+2 after a sub-word store returns the new data, because memory updates at the edge and the read is combinational.
  - A store immediately followed by a store needs no bubble beyond the RMW stall.
- **Reset values:** state=IDLE; `ld_data`=0; `ld_valid`=`err`=`stall`=0; merge registers 0.
- **Reset behaviour:** while `rst_n`=0, `mem_write`, `mem_read` and `stall` are forced to 0 combinationally. A reset during RMW_WR drops the write; the memory word keeps its old value.

## Configuration
- **`LSU_MISALIGN_CHECK_EN` defined:**
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, perform no access.
  - `err` pulses next cycle.
- **`LSU_MISALIGN_CHECK_EN` undefined:**
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`. The access is forced aligned.
  - `err` fires only for illegal funct3.

## Structure
- **Package `lsu_pkg`:**
  - funct3 constants (`F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101).
  - `lsu_state_t` enum {IDLE, RMW_WR}.
- **Sub-module `lsu_byte_lane`:** purely combinational. Performs lane merge for stores and lane extract plus extension for loads. Instantiated once.
- FSM, registers and memory-port muxing live in the top.

## Test plan
All scenarios use a memory model preloaded with word 3 = 0x8899AABB.
- **LB:** LB at byte addr 0x0D → N+1: `ld_valid`=1, `ld_data`=0xFFFFFFAA.
- **LBU / LH:**
  - LBU at 0x0D → 0x000000AA.
  - LH at 0x0E → 0xFFFF8899.
- **SB:** SB `wdata`=0x12345677 at 0x0C.
  - `stall`=1 for one cycle.
  - Write in RMW_WR of 0x8899AA77.
  - A following LW at 0x0C → 0x8899AA77.
- **SW then LHU:**
  - SW 0xDEADBEEF at 0x0C → one-cycle write, `stall`=0.
  - LHU at 0x0C → 0x0000BEEF.
- **Misalign / illegal:** with the macro defined, LW at 0x0E → no `mem_read`, `err`=1 at N+1, memory unchanged. funct3=011 → `err`=1.
- **Reset mid-RMW:** SH at 0x0C with `rst_n`=0 during RMW_WR → no write; word 3 stays 0x8899AABB; state IDLE; all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3
// encodings, the RMW FSM state type and the fixed data width.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic for the load/store unit.
// Store side: merges the right-aligned store data into the target byte or
// halfword lane of the word read from memory.
// Load side: extracts the target lane and sign- or zero-extends it.
// Halfword lanes are selected by addr_lo[1] only, so a halfword access is
// always forced onto an aligned lane; word accesses ignore addr_lo.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] st_word,
  output logic [XLEN-1:0] ld_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane merge for stores and lane extract/extend for loads.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would otherwise infer a latch.
    st_word = wdata;
    ld_word = rdata;
    lane_b  = rdata[{addr_lo, 3'b000} +: 8];
    lane_h  = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3[1:0])
      2'b00: begin
        st_word                         = rdata;
        st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        ld_word = funct3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      2'b01: begin
        st_word                              = rdata;
        st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        ld_word = funct3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        st_word = wdata;
        ld_word = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_subword_rmw.sv
// RV32I load/store unit in front of a word-only data memory.
// Loads: one combinational read, lane extract/extend, result registered.
// SW: single-cycle write. SB/SH: read + merge in IDLE (stalling the
// pipeline), then the merged word is written from registers in RMW_WR.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned halfword/word
// accesses raise err instead of being forced onto an aligned lane.
module lsu_subword_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DAT_WIDTH-1:0]  req_wdata,
  output logic                  stall,
  output logic                  ld_valid,
  output logic [DAT_WIDTH-1:0]  ld_data,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DAT_WIDTH-1:0]  mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic [DAT_WIDTH-1:0]  ld_data_q, ld_data_d;
  logic                  ld_valid_q, ld_valid_d;
  logic                  err_q, err_d;
  logic [DAT_WIDTH-1:0]  merge_q, merge_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;

  logic                  f3_legal;
  logic                  misaligned;
  logic                  req_ok;
  logic                  is_word;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [DAT_WIDTH-1:0]  lane_st_word;
  logic [DAT_WIDTH-1:0]  lane_ld_word;

  assign word_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};
  assign is_word  = (req_funct3 == F3_W);
  assign req_ok   = f3_legal && !misaligned;

  lsu_byte_lane u_lane (
    .funct3  (req_funct3),
    .addr_lo (req_addr[1:0]),
    .rdata   (mem_rdata),
    .wdata   (req_wdata),
    .st_word (lane_st_word),
    .ld_word (lane_ld_word)
  );

  // Request legality: unsigned variants exist only for loads, plus optional
  // alignment checking.
  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !req_write;
      default:          f3_legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only tested inside the clocked
    // block; all sequential state uses non-blocking assignments.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: only a legal sub-word store enters RMW_WR, which
  // always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && req_ok && req_write && !is_word) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic; memory strobes are gated by reset.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    stall      = 1'b0;
    mem_addr   = word_idx;
    mem_wdata  = req_wdata;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    err_d      = 1'b0;
    merge_d    = merge_q;
    waddr_d    = waddr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else if (!req_write) begin
            mem_read   = 1'b1;
            ld_valid_d = 1'b1;
            ld_data_d  = lane_ld_word;
          end else if (is_word) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            merge_d  = lane_st_word;
            waddr_d  = word_idx;
          end
        end
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = merge_q;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      stall     = 1'b0;
    end
  end

  // Load result, status pulses and RMW merge registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the merge registers are plain flops, not a memory array, so
      // they are reset like any other state to keep outputs deterministic.
      merge_q    <= '0;
      waddr_q    <= '0;
    end else begin
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      err_q      <= err_d;
      merge_q    <= merge_d;
      waddr_q    <= waddr_d;
    end
  end

  assign ld_data  = ld_data_q;
  assign ld_valid = ld_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Self-checking bench for lsu_subword_rmw: a behavioural word memory plus a
// reference model of the load/store rules, directed scenarios then random
// traffic, and a final memory comparison.
module tb_lsu_subword_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  lsu_subword_rmw #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, and the model's own copy.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ld = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Is this request performed at all?
  function automatic bit model_ok(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    bit ok;
    if (wr) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LSU_MISALIGN_CHECK_EN
    if (ok && (addr % (32'd1 << f3[1:0]) != 0)) ok = 0;
`endif
    return ok;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Byte offset of the access inside its word, after forced alignment.
  function automatic int offset_of(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    return int'(addr % 4) / sz * sz;
  endfunction

  function automatic logic [31:0] mask_of(input logic [2:0] f3);
    int sz = size_of(f3);
    if (sz == 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * sz)) - 32'd1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] word = ref_mem[addr[7:2]];
    logic [31:0] m    = mask_of(f3);
    logic [31:0] v    = (word >> (8 * offset_of(f3, addr))) & m;
    int          sz   = size_of(f3);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] wd);
    logic [31:0] word = ref_mem[addr[7:2]];
    logic [31:0] m    = mask_of(f3);
    int          sh   = 8 * offset_of(f3, addr);
    return (word & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // One request from issue to the registered result, checked at every cycle.
  task automatic txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    bit          ok  = model_ok(wr, f3, addr);
    bit          sub = wr && ok && (f3[1:0] != 2'b10);
    logic [31:0] new_word = model_store(f3, addr, wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    check("mem_read",  {31'b0, mem_read},  {31'b0, ok && (!wr || sub)});
    check("mem_write", {31'b0, mem_write}, {31'b0, ok && wr && !sub});
    check("stall",     {31'b0, stall},     {31'b0, sub});
    check("mem_addr",  mem_addr, {2'b00, addr[31:2]});
    if (ok && wr && !sub) check("sw_wdata", mem_wdata, new_word);
    if (ok && !wr) exp_ld = model_load(f3, addr);
    if (sub) begin
      @(negedge clk); #1;
      check("rmw_write", {31'b0, mem_write}, 32'd1);
      check("rmw_read",  {31'b0, mem_read},  32'd0);
      check("rmw_stall", {31'b0, stall},     32'd0);
      check("rmw_addr",  mem_addr, {26'b0, addr[7:2]});
      check("rmw_wdata", mem_wdata, new_word);
    end
    if (ok && wr) ref_mem[addr[7:2]] = new_word;
    @(posedge clk); #1;
    check("ld_valid", {31'b0, ld_valid}, {31'b0, ok && !wr});
    check("err",      {31'b0, err},      {31'b0, !ok});
    check("ld_data",  ld_data, exp_ld);
  endtask

  task automatic idle_cycle(input logic [31:0] addr);
    @(negedge clk);
    req_valid = 1'b0; req_addr = addr;
    #1;
    check("idle_read",  {31'b0, mem_read},  32'd0);
    check("idle_write", {31'b0, mem_write}, 32'd0);
    check("idle_addr",  mem_addr, {2'b00, addr[31:2]});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0101_0101 * i + 32'h1357_9BDF;
      ref_mem[i] = mem[i];
    end
    mem[3]     = 32'h8899_AABB;
    ref_mem[3] = 32'h8899_AABB;

    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h0C; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read",     {31'b0, mem_read},  32'd0);
    check("rst_write",    {31'b0, mem_write}, 32'd0);
    check("rst_stall",    {31'b0, stall},     32'd0);
    check("rst_ld_valid", {31'b0, ld_valid},  32'd0);
    check("rst_err",      {31'b0, err},       32'd0);
    check("rst_ld_data",  ld_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;

    // Loads from the preloaded word 3.
    txn(0, 3'b000, 32'h0D, 32'h0);
    check("lb_0d",  ld_data, 32'hFFFF_FFAA);
    txn(0, 3'b100, 32'h0D, 32'h0);
    check("lbu_0d", ld_data, 32'h0000_00AA);
    txn(0, 3'b001, 32'h0E, 32'h0);
    check("lh_0e",  ld_data, 32'hFFFF_8899);

    // Reset asserted during RMW_WR drops the write.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0C;
    req_wdata = 32'h5555_1234;
    #1;
    check("sh_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstrmw_write", {31'b0, mem_write}, 32'd0);
    check("rstrmw_stall", {31'b0, stall},     32'd0);
    @(posedge clk); #1;
    check("rstrmw_word3",    mem[3], 32'h8899_AABB);
    check("rstrmw_ld_valid", {31'b0, ld_valid}, 32'd0);
    check("rstrmw_err",      {31'b0, err},      32'd0);
    check("rstrmw_ld_data",  ld_data, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    #1;
    check("post_rst_idle_write", {31'b0, mem_write}, 32'd0);
    check("post_rst_idle_stall", {31'b0, stall},     32'd0);

    // SB merge, then read back.
    txn(1, 3'b000, 32'h0C, 32'h1234_5677);
    txn(0, 3'b010, 32'h0C, 32'h0);
    check("lw_after_sb", ld_data, 32'h8899_AA77);

    // SW then LHU.
    txn(1, 3'b010, 32'h0C, 32'hDEAD_BEEF);
    txn(0, 3'b101, 32'h0C, 32'h0);
    check("lhu_after_sw", ld_data, 32'h0000_BEEF);

    // Misaligned word load and illegal funct3 codes.
    txn(0, 3'b010, 32'h0E, 32'h0);
    txn(0, 3'b011, 32'h0C, 32'h0);
    txn(1, 3'b100, 32'h0C, 32'hFFFF_FFFF);
    txn(1, 3'b111, 32'h10, 32'hFFFF_FFFF);
    check("word3_after_illegal", mem[3], 32'hDEAD_BEEF);
    idle_cycle(32'h0000_0044);

    // Back-to-back sub-word stores and loads.
    txn(1, 3'b001, 32'h22, 32'h0000_CAFE);
    txn(1, 3'b000, 32'h21, 32'h0000_0042);
    txn(0, 3'b001, 32'h22, 32'h0);
    txn(0, 3'b100, 32'h21, 32'h0);

    // Random traffic.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle($urandom);
      else txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               32'($urandom_range(0, 255)), $urandom);
    end
    idle_cycle(32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
